// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined processor.
package cpu_pkg;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    localparam logic [RW-1:0] OP_LW  = 4'b1000;
    localparam logic [RW-1:0] OP_SW  = 4'b1001;
    localparam logic [RW-1:0] OP_PCS = 4'b1110;
    localparam logic [RW-1:0] OP_HLT = 4'b1111;

endpackage

// File: rtl/Register.sv
// Word register with write enable and synchronous active-high reset.
module Register #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wen_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (rst)        q_o <= '0;
        else if (wen_i) q_o <= d_i;
    end

endmodule

// File: rtl/dff.sv
// Single-bit flip-flop with synchronous active-high reset.
module dff (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    always_ff @(posedge clk) begin
        if (rst) q_o <= 1'b0;
        else     q_o <= d_i;
    end

endmodule

// File: rtl/memory_writeback_register.sv
// MEM/WB pipeline register: control bits clear on a bubble, data fields hold unless enabled.
module memory_writeback_register
    import cpu_pkg::*;
#(
    parameter int unsigned DW = cpu_pkg::DW,
    parameter int unsigned RW = cpu_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wen_i,
    input  logic          mem_wen_i,
    input  logic          bubble_i,
    input  logic          hlt_i,
    input  logic          mem_to_reg_i,
    input  logic          reg_write_i,
    input  logic          pcs_i,
    input  logic [RW-1:0] write_reg_i,
    input  logic [DW-1:0] next_pc_i,
    input  logic [DW-1:0] alu_out_i,
    input  logic [DW-1:0] mem_data_i,
    output logic          hlt_o,
    output logic          mem_to_reg_o,
    output logic          reg_write_o,
    output logic          pcs_o,
    output logic [RW-1:0] write_reg_o,
    output logic [DW-1:0] next_pc_o,
    output logic [DW-1:0] alu_out_o,
    output logic [DW-1:0] mem_data_o
);

    logic [3:0]    ctrl_d;
    logic [3:0]    ctrl_q;
    logic [RW-1:0] write_reg_d;

    assign ctrl_d      = bubble_i ? 4'b0000 : {hlt_i, mem_to_reg_i, reg_write_i, pcs_i};
    assign write_reg_d = wen_i ? write_reg_i : write_reg_o;

    for (genvar g = 0; g < 4; g++) begin : g_ctrl
        dff u_ctrl (.clk(clk), .rst(rst), .d_i(ctrl_d[g]), .q_o(ctrl_q[g]));
    end

    for (genvar g = 0; g < RW; g++) begin : g_wreg
        dff u_wreg (.clk(clk), .rst(rst), .d_i(write_reg_d[g]), .q_o(write_reg_o[g]));
    end

    assign {hlt_o, mem_to_reg_o, reg_write_o, pcs_o} = ctrl_q;

    Register #(.W(DW)) u_next_pc (
        .clk(clk), .rst(rst), .wen_i(wen_i), .d_i(next_pc_i), .q_o(next_pc_o)
    );

    Register #(.W(DW)) u_alu_out (
        .clk(clk), .rst(rst), .wen_i(wen_i), .d_i(alu_out_i), .q_o(alu_out_o)
    );

    Register #(.W(DW)) u_mem_data (
        .clk(clk), .rst(rst), .wen_i(mem_wen_i), .d_i(mem_data_i), .q_o(mem_data_o)
    );

endmodule

// File: rtl/memory_stage.sv
// Memory stage: multi-cycle data-memory access FSM, store-data forwarding and MEM/WB register.
module memory_stage #(
    parameter int unsigned DW = cpu_pkg::DW,
    parameter int unsigned RW = cpu_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hlt_xm,
    input  logic          mem_read_xm,
    input  logic          mem_write_xm,
    input  logic          mem_to_reg_xm,
    input  logic          reg_write_xm,
    input  logic          pcs_xm,
    input  logic [RW-1:0] write_reg_xm,
    input  logic [RW-1:0] rt_xm,
    input  logic [RW-1:0] opcode_xm,
    input  logic [DW-1:0] next_pc_xm,
    input  logic [DW-1:0] reg2_xm,
    input  logic [DW-1:0] alu_out_xm,
    output logic          dmem_req,
    output logic          dmem_we,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          dmem_ready,
    output logic          stall_mem,
    output logic          hlt_mw,
    output logic          mem_to_reg_mw,
    output logic          reg_write_mw,
    output logic          pcs_mw,
    output logic [RW-1:0] write_reg_mw,
    output logic [DW-1:0] next_pc_mw,
    output logic [DW-1:0] alu_out_mw,
    output logic [DW-1:0] mem_data_mw,
    output logic [DW-1:0] wb_data_mw
);

    import cpu_pkg::*;

    mem_state_t    state_q, state_d;
    logic [DW-1:0] addr_q, wdata_q, lbuf_q;
    logic          we_q;

    logic          access_c, is_load_c, fwd_c;
    logic [DW-1:0] wdata_c;
    logic          capture_c, lbuf_en_c, mw_wen_c, mw_mem_wen_c, mw_bubble_c;
    logic          unused_opcode_c;

    assign unused_opcode_c = ^opcode_xm;

    assign access_c  = mem_read_xm | mem_write_xm;
    assign is_load_c = mem_read_xm & ~mem_write_xm;

    // MEM-to-MEM forwarding from the instruction currently sitting in MEM/WB
    assign fwd_c   = mem_write_xm && reg_write_mw && (write_reg_mw == rt_xm) && (rt_xm != '0);
    assign wdata_c = fwd_c ? wb_data_mw : reg2_xm;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            lbuf_q  <= '0;
        end else begin
            state_q <= state_d;
            if (capture_c) begin
                addr_q  <= alu_out_xm;
                wdata_q <= wdata_c;
                we_q    <= mem_write_xm;
            end
            if (lbuf_en_c) lbuf_q <= dmem_rdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        dmem_req     = 1'b0;
        stall_mem    = 1'b0;
        capture_c    = 1'b0;
        lbuf_en_c    = 1'b0;
        mw_wen_c     = 1'b0;
        mw_mem_wen_c = 1'b0;
        mw_bubble_c  = 1'b0;
        if (!rst) begin
            unique case (state_q)
                IDLE: begin
                    if (access_c) begin
                        dmem_req    = 1'b1;
                        stall_mem   = 1'b1;
                        capture_c   = 1'b1;
                        mw_bubble_c = 1'b1;
                        state_d     = BUSY;
                    end else begin
                        mw_wen_c = 1'b1;
                    end
                end
                BUSY: begin
                    stall_mem   = 1'b1;
                    mw_bubble_c = 1'b1;
                    if (dmem_ready) begin
                        lbuf_en_c = 1'b1;
                        state_d   = DONE;
                    end
                end
                DONE: begin
                    mw_wen_c     = 1'b1;
                    mw_mem_wen_c = is_load_c;
                    state_d      = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Request-cycle values come straight from EX/MEM; afterwards from the holding registers
    assign dmem_addr  = (state_q == IDLE) ? alu_out_xm   : addr_q;
    assign dmem_wdata = (state_q == IDLE) ? wdata_c      : wdata_q;
    assign dmem_we    = (state_q == IDLE) ? mem_write_xm : we_q;

    memory_writeback_register #(.DW(DW), .RW(RW)) u_mw (
        .clk          (clk),
        .rst          (rst),
        .wen_i        (mw_wen_c),
        .mem_wen_i    (mw_mem_wen_c),
        .bubble_i     (mw_bubble_c),
        .hlt_i        (hlt_xm),
        .mem_to_reg_i (mem_to_reg_xm),
        .reg_write_i  (reg_write_xm),
        .pcs_i        (pcs_xm),
        .write_reg_i  (write_reg_xm),
        .next_pc_i    (next_pc_xm),
        .alu_out_i    (alu_out_xm),
        .mem_data_i   (lbuf_q),
        .hlt_o        (hlt_mw),
        .mem_to_reg_o (mem_to_reg_mw),
        .reg_write_o  (reg_write_mw),
        .pcs_o        (pcs_mw),
        .write_reg_o  (write_reg_mw),
        .next_pc_o    (next_pc_mw),
        .alu_out_o    (alu_out_mw),
        .mem_data_o   (mem_data_mw)
    );

    assign wb_data_mw = mem_to_reg_mw ? mem_data_mw : (pcs_mw ? next_pc_mw : alu_out_mw);

endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: acts as upstream pipeline and data memory, checks against a model.
module tb_memory_stage;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 4;

    logic          clk, rst;
    logic          hlt_xm, mem_read_xm, mem_write_xm, mem_to_reg_xm, reg_write_xm, pcs_xm;
    logic [RW-1:0] write_reg_xm, rt_xm, opcode_xm;
    logic [DW-1:0] next_pc_xm, reg2_xm, alu_out_xm;
    logic          dmem_req, dmem_we, dmem_ready, stall_mem;
    logic [DW-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic          hlt_mw, mem_to_reg_mw, reg_write_mw, pcs_mw;
    logic [RW-1:0] write_reg_mw;
    logic [DW-1:0] next_pc_mw, alu_out_mw, mem_data_mw, wb_data_mw;

    memory_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst(rst),
        .hlt_xm(hlt_xm), .mem_read_xm(mem_read_xm), .mem_write_xm(mem_write_xm),
        .mem_to_reg_xm(mem_to_reg_xm), .reg_write_xm(reg_write_xm), .pcs_xm(pcs_xm),
        .write_reg_xm(write_reg_xm), .rt_xm(rt_xm), .opcode_xm(opcode_xm),
        .next_pc_xm(next_pc_xm), .reg2_xm(reg2_xm), .alu_out_xm(alu_out_xm),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready), .stall_mem(stall_mem),
        .hlt_mw(hlt_mw), .mem_to_reg_mw(mem_to_reg_mw), .reg_write_mw(reg_write_mw),
        .pcs_mw(pcs_mw), .write_reg_mw(write_reg_mw), .next_pc_mw(next_pc_mw),
        .alu_out_mw(alu_out_mw), .mem_data_mw(mem_data_mw), .wb_data_mw(wb_data_mw)
    );

    typedef struct packed {
        logic        hlt, rd, wr, m2r, rw, pcs;
        logic [3:0]  wreg, rt, op;
        logic [15:0] npc, reg2, alu;
    } instr_t;

    // Architectural view of what MEM/WB should hold after the last retired instruction
    logic        e_hlt, e_m2r, e_rw, e_pcs;
    logic [3:0]  e_wreg;
    logic [15:0] e_npc, e_alu, e_mdata;
    logic [15:0] mem_model [16];

    int n_total = 0;
    int n_bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] e_wb();
        return e_m2r ? e_mdata : (e_pcs ? e_npc : e_alu);
    endfunction

    task automatic clear_model();
        {e_hlt, e_m2r, e_rw, e_pcs} = 4'b0;
        e_wreg = 4'd0; e_npc = 16'd0; e_alu = 16'd0; e_mdata = 16'd0;
    endtask

    task automatic check_mw(input string tag);
        chk({tag, ".hlt"},  16'(hlt_mw),        16'(e_hlt));
        chk({tag, ".m2r"},  16'(mem_to_reg_mw), 16'(e_m2r));
        chk({tag, ".rw"},   16'(reg_write_mw),  16'(e_rw));
        chk({tag, ".pcs"},  16'(pcs_mw),        16'(e_pcs));
        chk({tag, ".wreg"}, 16'(write_reg_mw),  16'(e_wreg));
        chk({tag, ".npc"},  next_pc_mw,  e_npc);
        chk({tag, ".alu"},  alu_out_mw,  e_alu);
        chk({tag, ".mdat"}, mem_data_mw, e_mdata);
        chk({tag, ".wb"},   wb_data_mw,  e_wb());
    endtask

    task automatic drive(input instr_t i);
        hlt_xm = i.hlt; mem_read_xm = i.rd; mem_write_xm = i.wr;
        mem_to_reg_xm = i.m2r; reg_write_xm = i.rw; pcs_xm = i.pcs;
        write_reg_xm = i.wreg; rt_xm = i.rt; opcode_xm = i.op;
        next_pc_xm = i.npc; reg2_xm = i.reg2; alu_out_xm = i.alu;
    endtask

    // Issue one instruction, play a memory with latency k, then check MEM/WB after it retires
    task automatic run(input string tag, input instr_t i, input int k);
        logic        acc, ld;
        logic [15:0] exp_wd;
        acc = i.rd | i.wr;
        ld  = i.rd & ~i.wr;
        exp_wd = (i.wr && e_rw && e_wreg == i.rt && i.rt != 4'd0) ? e_wb() : i.reg2;
        @(negedge clk);
        drive(i);
        #1;
        if (!acc) begin
            chk({tag, ".stall"}, 16'(stall_mem), 16'd0);
            chk({tag, ".req"},   16'(dmem_req),  16'd0);
        end else begin
            chk({tag, ".req0"},   16'(dmem_req),  16'd1);
            chk({tag, ".stall0"}, 16'(stall_mem), 16'd1);
            chk({tag, ".we0"},    16'(dmem_we),   16'(i.wr));
            chk({tag, ".addr0"},  dmem_addr, i.alu);
            if (i.wr) chk({tag, ".wd0"}, dmem_wdata, exp_wd);
            for (int c = 1; c <= k; c++) begin
                @(negedge clk);
                dmem_ready = (c == k);
                dmem_rdata = (c == k && ld) ? mem_model[i.alu[3:0]] : 16'($urandom);
                #1;
                chk({tag, ".stallB"}, 16'(stall_mem),    16'd1);
                chk({tag, ".reqB"},   16'(dmem_req),     16'd0);
                chk({tag, ".weB"},    16'(dmem_we),      16'(i.wr));
                chk({tag, ".addrB"},  dmem_addr, i.alu);
                chk({tag, ".bubB"},   16'(reg_write_mw), 16'd0);
                if (i.wr) chk({tag, ".wdB"}, dmem_wdata, exp_wd);
            end
            @(negedge clk);
            dmem_ready = 1'b0;
            dmem_rdata = 16'($urandom);
            #1;
            chk({tag, ".stallD"}, 16'(stall_mem),    16'd0);
            chk({tag, ".reqD"},   16'(dmem_req),     16'd0);
            chk({tag, ".bubD"},   16'(reg_write_mw), 16'd0);
            if (i.wr) mem_model[i.alu[3:0]] = exp_wd;
        end
        e_hlt = i.hlt; e_m2r = i.m2r; e_rw = i.rw; e_pcs = i.pcs;
        e_wreg = i.wreg; e_npc = i.npc; e_alu = i.alu;
        if (ld) e_mdata = mem_model[i.alu[3:0]];
        @(posedge clk);
        #1;
        check_mw(tag);
    endtask

    function automatic instr_t rand_instr();
        instr_t i;
        i      = '0;
        i.wreg = 4'($urandom_range(0, 3));
        i.rt   = 4'($urandom_range(0, 3));
        i.npc  = 16'($urandom);
        i.reg2 = 16'($urandom);
        i.alu  = 16'($urandom);
        case ($urandom_range(0, 5))
            0: begin i.rw = 1'b1; i.op = 4'b0000; end
            1: begin i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.op = 4'b1000; end
            2: begin i.wr = 1'b1; i.op = 4'b1001; end
            3: begin i.pcs = 1'b1; i.rw = 1'b1; i.op = 4'b1110; end
            4: begin i.hlt = 1'b1; i.op = 4'b1111; end
            default: begin i.rd = 1'b1; i.wr = 1'b1; i.rw = 1'($urandom); end
        endcase
        return i;
    endfunction

    initial begin
        instr_t i;
        for (int a = 0; a < 16; a++) mem_model[a] = 16'($urandom);
        rst = 1'b1;
        drive('0);
        dmem_ready = 1'b0;
        dmem_rdata = 16'd0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.stall", 16'(stall_mem), 16'd0);
        chk("rst.req",   16'(dmem_req),  16'd0);
        check_mw("rst");
        @(negedge clk);
        rst = 1'b0;

        i = '0; i.rw = 1'b1; i.wreg = 4'd5; i.alu = 16'h1234; i.npc = 16'h0102;
        run("alu", i, 0);

        mem_model[0] = 16'hBEEF;
        i = '0; i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.wreg = 4'd2; i.alu = 16'h0040; i.op = 4'b1000;
        run("lw", i, 1);
        chk("lw.beef", wb_data_mw, 16'hBEEF);

        i = '0; i.wr = 1'b1; i.rt = 4'd7; i.reg2 = 16'h00AA; i.alu = 16'h0010; i.op = 4'b1001;
        run("sw", i, 3);
        chk("sw.mdat", mem_data_mw, 16'hBEEF);

        mem_model[2] = 16'h5555;
        i = '0; i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.wreg = 4'd3; i.alu = 16'h0002;
        run("lw_r3", i, 2);
        i = '0; i.wr = 1'b1; i.rt = 4'd3; i.reg2 = 16'h0000; i.alu = 16'h0004;
        run("sw_fwd", i, 1);
        chk("sw_fwd.mem", mem_model[4], 16'h5555);

        i = '0; i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.wreg = 4'd0; i.alu = 16'h0002;
        run("lw_r0", i, 1);
        i = '0; i.wr = 1'b1; i.rt = 4'd0; i.reg2 = 16'h0707; i.alu = 16'h0005;
        run("sw_r0", i, 2);
        chk("sw_r0.mem", mem_model[5], 16'h0707);

        // Reset during BUSY, then a late ready that must be ignored
        i = '0; i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.wreg = 4'd1; i.alu = 16'h0006;
        @(negedge clk);
        drive(i);
        @(negedge clk);
        rst = 1'b1;
        drive('0);
        @(negedge clk);
        rst = 1'b0;
        dmem_ready = 1'b1;
        dmem_rdata = 16'hDEAD;
        clear_model();
        #1;
        chk("rstb.stall", 16'(stall_mem), 16'd0);
        chk("rstb.req",   16'(dmem_req),  16'd0);
        check_mw("rstb");
        @(negedge clk);
        dmem_ready = 1'b0;
        #1;
        chk("rstb.stall2", 16'(stall_mem), 16'd0);
        check_mw("rstb2");

        i = '0; i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.wreg = 4'd4; i.alu = 16'h0008; i.npc = 16'h0020;
        run("b2b0", i, 1);
        i = '0; i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.wreg = 4'd6; i.alu = 16'h0009; i.npc = 16'h0022;
        run("b2b1", i, 2);

        for (int n = 0; n < 200; n++) begin
            run("rnd", rand_instr(), int'($urandom_range(1, 4)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
